// File: rtl/sa_result_reader.sv
// Readback path from the systolic array bottom outputs to the core DMA input.
// Rows are captured into a small FIFO and returned as two 32-bit words per row.
module sa_result_reader #(
    parameter logic [7:0] CAP_ADDR  = 8'h0A,
    parameter logic [7:0] READ_ADDR = 8'h0C,
    parameter logic [7:0] CLR_ADDR  = 8'h0E,
    parameter logic [7:0] CAP_ROWS  = 8'd7,
    parameter int         DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_rw,
    input  logic [7:0]               uart_in,
    input  logic                     ps_valid,
    input  logic [15:0]              ps_in0,
    input  logic [15:0]              ps_in1,
    input  logic [15:0]              ps_in2,
    input  logic [15:0]              ps_in3,
    output logic [31:0]              dma_out,
    output logic                     dma_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     capturing,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {LO, HI} rd_state_e;

    rd_state_e   state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    cap_rem_q, cap_rem_d;
    logic          capturing_q;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic [31:0]   dma_out_q, dma_out_d;
    logic          dma_valid_q, dma_valid_d;
    logic [63:0]   mem_q [DEPTH];

    logic        cmd_cap, cmd_read, cmd_clr;
    logic        push_req, push_ok, pop;
    logic [63:0] row_in, head;

    assign cmd_cap  = uart_rw && (uart_in == CAP_ADDR);
    assign cmd_read = uart_rw && (uart_in == READ_ADDR);
    assign cmd_clr  = uart_rw && (uart_in == CLR_ADDR);
    assign row_in   = {ps_in3, ps_in2, ps_in1, ps_in0};
    assign head     = mem_q[rd_ptr_q];
    assign push_req = (cap_rem_q != 8'd0) && ps_valid;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        cap_rem_d   = cap_rem_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        dma_out_d   = dma_out_q;
        dma_valid_d = 1'b0;
        push_ok     = 1'b0;
        pop         = 1'b0;

        if (cmd_clr) begin
            state_d     = LO;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            cap_rem_d   = 8'd0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            dma_out_d   = 32'd0;
        end else begin
            case (state_q)
                LO: begin
                    if (cmd_read) begin
                        if (count_q != '0) begin
                            dma_out_d   = head[31:0];
                            dma_valid_d = 1'b1;
                            state_d     = HI;
                        end else begin
                            underflow_d = 1'b1;
                        end
                    end
                end
                HI: begin
                    if (cmd_read) begin
                        dma_out_d   = head[63:32];
                        dma_valid_d = 1'b1;
                        state_d     = LO;
                        pop         = 1'b1;
                    end
                end
                default: state_d = LO;
            endcase

            // A full FIFO still accepts a row when the head leaves in the same cycle.
            if (push_req) begin
                if ((count_q != FULL_CNT) || pop) begin
                    push_ok = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end

            if (cmd_cap) begin
                cap_rem_d = CAP_ROWS;
            end else if (push_req) begin
                cap_rem_d = cap_rem_q - 8'd1;
            end

            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push_ok && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push_ok) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LO;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cap_rem_q   <= 8'd0;
            capturing_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dma_out_q   <= 32'd0;
            dma_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cap_rem_q   <= cap_rem_d;
            capturing_q <= (cap_rem_d != 8'd0);
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dma_out_q   <= dma_out_d;
            dma_valid_q <= dma_valid_d;
        end
    end

    // Row storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= row_in;
        end
    end

    assign dma_out    = dma_out_q;
    assign dma_valid  = dma_valid_q;
    assign fifo_count = count_q;
    assign capturing  = capturing_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_sa_result_reader.sv
// Directed bench for sa_result_reader: a queue-based model is compared against
// the DUT every cycle, with literal expectations pinning key points.
module tb_sa_result_reader;

    localparam logic [7:0] CAP  = 8'h0A;
    localparam logic [7:0] RD   = 8'h0C;
    localparam logic [7:0] CLR  = 8'h0E;
    localparam logic [7:0] NOP  = 8'h00;

    logic        clk;
    logic        rst;
    logic        uart_rw;
    logic [7:0]  uart_in;
    logic        ps_valid;
    logic [15:0] ps_in0, ps_in1, ps_in2, ps_in3;
    logic [31:0] dma_out;
    logic        dma_valid;
    logic [3:0]  fifo_count;
    logic        capturing;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    sa_result_reader dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rw    (uart_rw),
        .uart_in    (uart_in),
        .ps_valid   (ps_valid),
        .ps_in0     (ps_in0),
        .ps_in1     (ps_in1),
        .ps_in2     (ps_in2),
        .ps_in3     (ps_in3),
        .dma_out    (dma_out),
        .dma_valid  (dma_valid),
        .fifo_count (fifo_count),
        .capturing  (capturing),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: rows held in a queue, half-word position as a flag.
    logic [63:0] m_q[$];
    int          m_cap;
    bit          m_hi;
    logic [31:0] m_dout;
    bit          m_valid, m_ovf, m_unf;
    bit          m_started = 0;

    always @(posedge clk) begin
        bit is_read, is_cap, is_clr, pushing, popped;
        logic [63:0] row;
        row     = {ps_in3, ps_in2, ps_in1, ps_in0};
        is_read = uart_rw && uart_in == RD;
        is_cap  = uart_rw && uart_in == CAP;
        is_clr  = uart_rw && uart_in == CLR;
        pushing = (m_cap > 0) && ps_valid;
        popped  = 0;
        m_valid = 0;
        if (rst) begin
            m_q.delete();
            m_cap = 0; m_hi = 0; m_dout = 0; m_ovf = 0; m_unf = 0;
            m_started = 1;
        end else if (is_clr) begin
            m_q.delete();
            m_cap = 0; m_hi = 0; m_dout = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (is_read) begin
                if (m_hi) begin
                    m_dout = m_q[0][63:32];
                    m_hi = 0; m_valid = 1; popped = 1;
                end else if (m_q.size() > 0) begin
                    m_dout = m_q[0][31:0];
                    m_hi = 1; m_valid = 1;
                end else begin
                    m_unf = 1;
                end
            end
            if (pushing) begin
                if (m_q.size() < 8 || popped) m_q.push_back(row);
                else m_ovf = 1;
            end
            if (popped) void'(m_q.pop_front());
            if (is_cap) m_cap = 7;
            else if (pushing) m_cap = m_cap - 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_started) begin
            checkOutput("dma_out",    dma_out,            m_dout);
            checkOutput("dma_valid",  32'(dma_valid),     32'(m_valid));
            checkOutput("fifo_count", 32'(fifo_count),    32'(m_q.size()));
            checkOutput("capturing",  32'(capturing),     32'(m_cap > 0));
            checkOutput("overflow",   32'(overflow),      32'(m_ovf));
            checkOutput("underflow",  32'(underflow),     32'(m_unf));
        end
    end

    // One call is one clock cycle; inputs return to idle just after the edge.
    task automatic applyStimulus(input logic r, input logic [7:0] cmd, input logic pv,
                                 input logic [15:0] base);
        @(negedge clk);
        rst      = r;
        uart_rw  = (cmd != NOP);
        uart_in  = cmd;
        ps_valid = pv;
        ps_in0   = base;
        ps_in1   = base + 16'd1;
        ps_in2   = base + 16'd2;
        ps_in3   = base + 16'd3;
        @(posedge clk);
        #1;
        rst = 1'b0; uart_rw = 1'b0; uart_in = NOP; ps_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; uart_rw = 1'b0; uart_in = NOP; ps_valid = 1'b0;
        ps_in0 = 0; ps_in1 = 0; ps_in2 = 0; ps_in3 = 0;
        applyStimulus(1, NOP, 0, 0);
        applyStimulus(1, NOP, 0, 0);
        checkOutput("reset_dma_out", dma_out, 32'h0);
        checkOutput("reset_count", 32'(fifo_count), 32'd0);
        applyStimulus(0, NOP, 0, 0);

        $display("[TB] capture 7 rows and read back");
        applyStimulus(0, CAP, 0, 0);
        checkOutput("cap_high", 32'(capturing), 32'd1);
        for (int r = 1; r <= 7; r++) applyStimulus(0, NOP, 1, 16'(r * 16));
        checkOutput("count_after_cap", 32'(fifo_count), 32'd7);
        checkOutput("cap_low", 32'(capturing), 32'd0);
        applyStimulus(0, RD, 0, 0);
        checkOutput("word0", dma_out, 32'h0011_0010);
        applyStimulus(0, RD, 0, 0);
        checkOutput("word1", dma_out, 32'h0013_0012);
        for (int i = 0; i < 12; i++) applyStimulus(0, RD, 0, 0);
        checkOutput("last_word", dma_out, 32'h0073_0072);
        checkOutput("count_drained", 32'(fifo_count), 32'd0);
        applyStimulus(0, NOP, 0, 0);

        $display("[TB] overflow on 9th row");
        applyStimulus(0, CAP, 0, 0);
        for (int r = 0; r < 7; r++) applyStimulus(0, NOP, 1, 16'(16'h100 + r * 16));
        applyStimulus(0, CAP, 0, 0);
        applyStimulus(0, NOP, 1, 16'h0200);
        applyStimulus(0, NOP, 1, 16'h0300);
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        checkOutput("ovf_count", 32'(fifo_count), 32'd8);
        for (int i = 0; i < 16; i++) applyStimulus(0, RD, 0, 0);
        checkOutput("ovf_last_word", dma_out, 32'h0203_0202);
        applyStimulus(0, CLR, 0, 0);

        $display("[TB] read on empty FIFO");
        applyStimulus(0, CAP, 0, 0);
        applyStimulus(0, NOP, 1, 16'h0500);
        applyStimulus(0, RD, 0, 0);
        applyStimulus(0, RD, 0, 0);
        applyStimulus(0, RD, 0, 0);
        checkOutput("unf_set", 32'(underflow), 32'd1);
        checkOutput("unf_hold", dma_out, 32'h0503_0502);
        checkOutput("unf_no_valid", 32'(dma_valid), 32'd0);
        applyStimulus(0, RD, 0, 0);
        applyStimulus(0, CLR, 0, 0);

        $display("[TB] full FIFO, simultaneous pop and push");
        applyStimulus(0, CAP, 0, 0);
        for (int r = 0; r < 7; r++) applyStimulus(0, NOP, 1, 16'(16'h1000 + r * 16));
        applyStimulus(0, CAP, 0, 0);
        applyStimulus(0, NOP, 1, 16'h2000);
        applyStimulus(0, RD, 0, 0);
        applyStimulus(0, RD, 1, 16'h3000);
        checkOutput("full_count", 32'(fifo_count), 32'd8);
        checkOutput("full_no_ovf", 32'(overflow), 32'd0);
        checkOutput("full_hi_word", dma_out, 32'h1003_1002);
        for (int i = 0; i < 16; i++) applyStimulus(0, RD, 0, 0);
        checkOutput("full_tail_word", dma_out, 32'h3003_3002);

        $display("[TB] clear while in high half");
        applyStimulus(0, CLR, 0, 0);
        applyStimulus(0, CAP, 0, 0);
        for (int r = 0; r < 3; r++) applyStimulus(0, NOP, 1, 16'(16'h4000 + r * 16));
        applyStimulus(0, RD, 0, 0);
        applyStimulus(0, CLR, 0, 0);
        checkOutput("clr_dma", dma_out, 32'h0);
        checkOutput("clr_count", 32'(fifo_count), 32'd0);
        applyStimulus(0, RD, 0, 0);
        checkOutput("clr_then_unf", 32'(underflow), 32'd1);

        $display("[TB] reset mid-capture");
        applyStimulus(0, CLR, 0, 0);
        applyStimulus(0, CAP, 0, 0);
        for (int r = 0; r < 3; r++) applyStimulus(0, NOP, 1, 16'(16'h5000 + r * 16));
        applyStimulus(1, NOP, 1, 16'h5030);
        checkOutput("rst_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_cap", 32'(capturing), 32'd0);
        for (int r = 0; r < 3; r++) applyStimulus(0, NOP, 1, 16'h6000);
        checkOutput("rst_ignore_pv", 32'(fifo_count), 32'd0);
        applyStimulus(0, CAP, 0, 0);
        applyStimulus(0, NOP, 1, 16'h7000);
        applyStimulus(0, RD, 0, 0);
        checkOutput("rst_recap_word", dma_out, 32'h7001_7000);
        applyStimulus(0, NOP, 0, 0);
        applyStimulus(0, NOP, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sa_result_reader.md
# sa_result_reader

Readback path from the 4x4 systolic array to the RV32IM core: captures rows of bottom partial-sum outputs into a small FIFO and returns them to the CPU over the 32-bit DMA input, two lanes per word. It listens on the same byte command bus (uart_rw / uart_data) as the shift and data-load blocks. It sits between the array's ps_bottom_out_flat and the core's DMA_in.

## Interface
- CAP_ADDR, 8'h0A: command byte that arms capture of CAP_ROWS rows.
- READ_ADDR, 8'h0C: command byte that advances the DMA word (low half, then high half with pop).
- CLR_ADDR, 8'h0E: command byte that flushes FIFO and clears status.
- CAP_ROWS, 7: rows captured per arm (2N-1 drain cycles for N=4); range 1..255.
- DEPTH, 8: FIFO rows; power of 2, at least 2.

- Clock  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_rw  in  1  command strobe; each cycle high is one command.
- uart_in  in  8  command byte, valid when uart_rw=1.
- ps_valid  in  1  array output row valid (tied to en_shift_bottom).
- ps_in0..ps_in3  in  16 each  lane 0..3 of the array bottom output.
- dma_out  out  32  word presented to core DMA_in.
- dma_valid  out  1  one-cycle pulse when dma_out is updated.
- fifo_count  out  $clog2(DEPTH)+1  rows stored.
- capturing  out  1  high while cap_remaining > 0.
- overflow  out  1  sticky; a row was dropped because the FIFO was full.
- underflow  out  1  sticky; READ_ADDR was issued while the FIFO was empty.

## Operation
- Row format: {ps_in3, ps_in2, ps_in1, ps_in0}, 64 bits; no arithmetic, lanes passed unmodified.
- Command decode happens only when uart_rw=1. A byte matching none of the three addresses is ignored.
- CAP_ADDR: cap_remaining <= CAP_ROWS. Issuing it while already capturing reloads the counter; stored rows are kept.
- Capture: each cycle with cap_remaining>0 and ps_valid=1 pushes one row and decrements cap_remaining. ps_valid while not capturing is ignored.
- Push when full:
  - If a pop also occurs this cycle, the push succeeds.
  - Otherwise the row is dropped, overflow <= 1, and the counter still decrements.
- Read FSM, states LO and HI (reset LO):
  - LO + READ, FIFO non-empty: dma_out <= head[31:0], go to HI.
  - HI + READ: dma_out <= head[63:32], pop head, go to LO.
  - LO + READ, FIFO empty: underflow <= 1, dma_out holds, no dma_valid pulse.
  - HI is reachable only with a non-empty FIFO; CLR is the only other exit.
- CLR_ADDR:
  - Pointers, count and cap_remaining go to 0.
  - overflow and underflow clear.
  - FSM goes to LO and dma_out <= 0.
  - Any push in the same cycle is discarded.
- Pointers wrap modulo DEPTH. fifo_count counts 0..DEPTH.

## Timing
- Reset (rst=1 at a clock edge): dma_out=0, dma_valid=0, fifo_count=0, capturing=0, overflow=0, underflow=0, FSM=LO, pointers=0. rst overrides all commands and pushes in that cycle.
- Reset asserted mid-capture or mid-read aborts the operation; no partial state survives.
- Command latency: dma_out and dma_valid update on the edge after uart_rw is sampled, i.e. 1 cycle. dma_valid is high for exactly that cycle.
- Push latency: a row sampled at edge k is counted in fifo_count after edge k and is readable by a READ sampled at edge k+1. There is no same-cycle bypass: READ on an empty FIFO plus a simultaneous push gives underflow, and the row is stored.
- The core may issue back-to-back READs on consecutive cycles; throughput is 1 word/cycle.
- capturing is registered; it goes high the cycle after CAP_ADDR and drops the cycle after the last counted ps_valid.

## Test plan
- Reset, then CAP_ADDR with 7 ps_valid rows, lanes = {row,row+1,row+2,row+3} for row=0x10·r. Then 14 READs. Required: words alternate {0x0011,0x0010}, {0x0013,0x0012}, …; fifo_count 7→0; no sticky flags.
- Fill all 8 rows over two arms, then push a 9th with no pop. Required: overflow=1, fifo_count=8, the 9th row is never read.
- READ on an empty FIFO. Required: underflow=1, dma_out unchanged, dma_valid=0, FSM stays LO.
- FIFO full and in state HI; READ and ps_valid in the same cycle. Required: pop and push both succeed, fifo_count stays 8, overflow stays 0.
- CLR_ADDR in state HI with 3 rows stored. Required: dma_out=0, count=0, next READ gives underflow.
- rst pulsed at the 4th row of a capture. Required: all outputs return to reset values, and later ps_valid is ignored until the next CAP_ADDR.
